// File: rtl/joy_trackball_emu.sv
// Joystick-driven trackball emulator: per-axis velocity ramp plus phase accumulator producing DIR/CLK quadrature-style pairs.
// Optional MOUSE_INPUT_EN adds signed mouse deltas that drain as extra steps when the joystick is quiet.
`timescale 1ns/1ps

module joy_trackball_axis #(
    parameter int ACCEL     = 2,
    parameter int DECEL     = 4,
    parameter int MAX_SPEED = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame,
    input  logic             tick,
    input  logic             pos,
    input  logic             neg,
`ifdef MOUSE_INPUT_EN
    input  logic signed [8:0] mouse_d,
    input  logic             mouse_stb,
`endif
    output logic             dir,
    output logic             tclk,
    output logic [7:0]       vel
);

    localparam logic signed [8:0] ACCEL_S = 9'(ACCEL);
    localparam logic signed [8:0] DECEL_S = 9'(DECEL);
    localparam logic signed [8:0] MAX_S   = 9'(MAX_SPEED);

    typedef enum logic [0:0] {IDLE = 1'b0, SETUP = 1'b1} state_t;

    state_t            state_r, state_nxt_s;
    logic signed [7:0] vel_r;
    logic [7:0]        acc_r;
    logic              dir_r, clk_r, dir_nxt_s, tog_s;
    logic [7:0]        mag_s;
    logic [8:0]        sum_s;
    logic              joy_req_s, joy_sign_s, req_s, req_sign_s;

    // 9-bit saturating velocity step: ramp toward the held direction, otherwise decay to zero without crossing.
    function automatic logic signed [7:0] vel_next(input logic signed [7:0] v, input logic p, input logic n);
        logic signed [8:0] v9;
        logic signed [8:0] s9;
        v9 = {v[7], v};
        s9 = v9;
        if (p && !n) begin
            s9 = v9 + ACCEL_S;
            if (s9 > MAX_S) s9 = MAX_S;
            else            s9 = s9;
        end else if (n && !p) begin
            s9 = v9 - ACCEL_S;
            if (s9 < -MAX_S) s9 = -MAX_S;
            else             s9 = s9;
        end else if (v9 > 9'sd0) begin
            s9 = v9 - DECEL_S;
            if (s9 < 9'sd0) s9 = 9'sd0;
            else            s9 = s9;
        end else if (v9 < 9'sd0) begin
            s9 = v9 + DECEL_S;
            if (s9 > 9'sd0) s9 = 9'sd0;
            else            s9 = s9;
        end else begin
            s9 = 9'sd0;
        end
        return s9[7:0];
    endfunction

    assign mag_s      = vel_r[7] ? (8'd0 - vel_r) : vel_r;
    assign sum_s      = {1'b0, acc_r} + {1'b0, mag_s};
    assign joy_req_s  = tick & sum_s[8];
    assign joy_sign_s = ~vel_r[7];

`ifdef MOUSE_INPUT_EN
    logic signed [8:0]  pend_r;
    logic signed [10:0] pend_sum_s;
    logic signed [10:0] drain_s;
    logic               mouse_req_s, mouse_sign_s;

    assign mouse_sign_s = ~pend_r[8];
    assign mouse_req_s  = tick & ~joy_req_s & (state_r == IDLE) & (pend_r != 9'sd0);
    assign req_s        = joy_req_s | mouse_req_s;
    assign req_sign_s   = joy_req_s ? joy_sign_s : mouse_sign_s;

    // Pending mouse total: add strobed delta, remove the step being issued, saturate at +/-255.
    always_comb begin
        drain_s    = 11'sd0;
        pend_sum_s = {{2{pend_r[8]}}, pend_r};
        if (mouse_req_s) drain_s = mouse_sign_s ? 11'sd1 : -11'sd1;
        else             drain_s = 11'sd0;
        if (mouse_stb) pend_sum_s = pend_sum_s + {{2{mouse_d[8]}}, mouse_d};
        else           pend_sum_s = pend_sum_s;
        pend_sum_s = pend_sum_s - drain_s;
    end

    // Pending mouse counter register.
    always_ff @(posedge clk) begin
        if (reset)                        pend_r <= 9'sd0;
        else if (pend_sum_s > 11'sd255)   pend_r <= 9'sd255;
        else if (pend_sum_s < -11'sd255)  pend_r <= -9'sd255;
        else                              pend_r <= pend_sum_s[8:0];
    end
`else
    assign req_s      = joy_req_s;
    assign req_sign_s = joy_sign_s;
`endif

    // Velocity and phase accumulator; the accumulator sees the pre-frame velocity on a shared cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vel_r <= 8'sd0;
            acc_r <= 8'd0;
        end else begin
            if (frame) vel_r <= vel_next(vel_r, pos, neg);
            if (tick)  acc_r <= sum_s[7:0];
        end
    end

    // Step FSM state plus registered DIR/CLK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            clk_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            dir_r   <= dir_nxt_s;
            clk_r   <= clk_r ^ tog_s;
        end
    end

    // Next state: a reversing step parks in SETUP until the following tick.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && (dir_r != req_sign_s)) state_nxt_s = SETUP;
                else                                 state_nxt_s = IDLE;
            end
            SETUP: begin
                if (tick) state_nxt_s = IDLE;
                else      state_nxt_s = SETUP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs: DIR and CLK never change in the same cycle; carries during SETUP are dropped.
    always_comb begin
        dir_nxt_s = dir_r;
        tog_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (dir_r == req_sign_s) tog_s     = 1'b1;
                    else                     dir_nxt_s = req_sign_s;
                end else begin
                    tog_s = 1'b0;
                end
            end
            SETUP: begin
                if (tick) tog_s = 1'b1;
                else      tog_s = 1'b0;
            end
            default: begin
                dir_nxt_s = dir_r;
                tog_s     = 1'b0;
            end
        endcase
    end

    assign dir  = dir_r;
    assign tclk = clk_r;
    assign vel  = vel_r;

endmodule

module joy_trackball_emu #(
    parameter int TICK_DIV  = 250,
    parameter int ACCEL     = 2,
    parameter int DECEL     = 4,
    parameter int MAX_SPEED = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VBLANK,
    input  logic        JOY_L,
    input  logic        JOY_R,
    input  logic        JOY_U,
    input  logic        JOY_D,
`ifdef MOUSE_INPUT_EN
    input  logic [8:0]  MOUSE_DX,
    input  logic [8:0]  MOUSE_DY,
    input  logic        MOUSE_STB,
`endif
    output logic        TBH_DIR,
    output logic        TBH_CLK,
    output logic        TBV_DIR,
    output logic        TBV_CLK,
    output logic [7:0]  VELX,
    output logic [7:0]  VELY
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;
    logic          vblank_d_r;
    logic          frame_s;

    assign tick_s  = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign frame_s = VBLANK & ~vblank_d_r;

    // Step-tick divider and VBLANK edge register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
            vblank_d_r <= 1'b0;
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + 1'b1;
            vblank_d_r <= VBLANK;
        end
    end

    joy_trackball_axis #(.ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)) u_h (
        .clk(clk), .reset(reset), .frame(frame_s), .tick(tick_s),
        .pos(JOY_R), .neg(JOY_L),
`ifdef MOUSE_INPUT_EN
        .mouse_d($signed(MOUSE_DX)), .mouse_stb(MOUSE_STB),
`endif
        .dir(TBH_DIR), .tclk(TBH_CLK), .vel(VELX)
    );

    joy_trackball_axis #(.ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)) u_v (
        .clk(clk), .reset(reset), .frame(frame_s), .tick(tick_s),
        .pos(JOY_D), .neg(JOY_U),
`ifdef MOUSE_INPUT_EN
        .mouse_d($signed(MOUSE_DY)), .mouse_stb(MOUSE_STB),
`endif
        .dir(TBV_DIR), .tclk(TBV_CLK), .vel(VELY)
    );

endmodule
